// File: rtl/mac_seq_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Brief    : Burst sequencer feeding the shared 8x8 multiplier and summing
//            its products into a wide accumulator with a sticky carry flag.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int c_sum_w = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_op_v;
  logic [7:0]         r_mul_a;
  logic [7:0]         r_mul_b;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic               w_handshake;
  logic [c_sum_w-1:0] w_sum;

  // Outputs decode directly from flops, so in_ready never depends on in_valid.
  assign in_ready    = (r_state == S_RUN) && (r_remaining != '0);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign acc         = r_acc;
  assign ovf         = r_ovf;

  assign w_handshake = in_valid & in_ready;
  assign w_sum       = {1'b0, r_acc} + c_sum_w'(mul_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_op_v      <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_op_v      <= 1'b0;
            r_remaining <= len;
            r_state     <= (len != '0) ? S_RUN : S_DONE;
          end
        end

        S_RUN: begin
          // Product of the pair captured last cycle is on mul_p now.
          if (r_op_v) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
          end
          if (w_handshake) begin
            r_mul_a     <= in_a;
            r_mul_b     <= in_b;
            r_op_v      <= 1'b1;
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_op_v <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (r_op_v) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
          end
          r_op_v  <= 1'b0;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Brief    : Randomized bench for mac_seq_ctrl, 20-bit and 16-bit accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;

  logic        in_ready20, busy20, done20, ovf20;
  logic [7:0]  mul_a20, mul_b20;
  logic [15:0] mul_p20;
  logic [19:0] acc20;

  logic        in_ready16, busy16, done16, ovf16;
  logic [7:0]  mul_a16, mul_b16;
  logic [15:0] mul_p16;
  logic [15:0] acc16;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pa[16];
  int pb[16];
  int st[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-ins for the combinational multiplier.
  assign mul_p20 = {8'h00, mul_a20} * {8'h00, mul_b20};
  assign mul_p16 = {8'h00, mul_a16} * {8'h00, mul_b16};

  mac_seq_ctrl #(.ACC_W(20), .CNT_W(4)) dut20 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready20), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a20), .mul_b(mul_b20), .mul_p(mul_p20),
    .busy(busy20), .done(done20), .acc(acc20), .ovf(ovf20)
  );

  mac_seq_ctrl #(.ACC_W(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_p(mul_p16),
    .busy(busy16), .done(done16), .acc(acc16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready20"}, 32'(in_ready20), 0);
    chk({tag, "_ready16"}, 32'(in_ready16), 0);
    chk({tag, "_mula"},    32'(mul_a20), 0);
    chk({tag, "_mulb"},    32'(mul_b16), 0);
    chk({tag, "_acc20"},   32'(acc20), 0);
    chk({tag, "_acc16"},   32'(acc16), 0);
    chk({tag, "_ovf16"},   32'(ovf16), 0);
    chk({tag, "_done"},    32'(done20 | done16), 0);
    chk({tag, "_busy"},    32'(busy20 | busy16), 0);
  endtask

  // Runs one burst of n pairs from pa/pb with st[i] idle cycles before pair i.
  task automatic run_burst(input int n, input bit start_in_run, input bit start_in_done);
    longint sum = 0;
    int     stalls = 0;
    int     s;
    int     w;
    int     exp_lat;
    for (int i = 0; i < n; i++) begin
      sum    += longint'(pa[i] * pb[i]);
      stalls += st[i];
    end
    exp_lat = (n == 0) ? 0 : n + 1 + stalls;

    start = 1'b1;
    len   = 4'(n);
    s     = cyc + 1;
    tick();
    start = start_in_run;
    if (start_in_run) len = 4'd15;
    chk("busy_rise20", 32'(busy20), 1);
    chk("busy_rise16", 32'(busy16), 1);
    chk("acc_clear", 32'(acc20) | 32'(acc16), 0);
    chk("ovf_clear", 32'(ovf20) | 32'(ovf16), 0);

    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < st[i]; k++) begin
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        chk("ready_stall", 32'(in_ready20 & in_ready16), 1);
        tick();
      end
      in_valid = 1'b1;
      in_a     = 8'(pa[i]);
      in_b     = 8'(pb[i]);
      w = 0;
      while (!in_ready20 && w < 10) begin
        tick();
        w++;
      end
      chk("ready_hs20", 32'(in_ready20), 1);
      chk("ready_hs16", 32'(in_ready16), 1);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;

    w = 0;
    while (!done20 && w < 30) begin
      chk("ready_low", 32'(in_ready20 | in_ready16), 0);
      tick();
      w++;
    end
    chk("done20", 32'(done20), 1);
    chk("done16", 32'(done16), 1);
    chk("latency", 32'(cyc - s), 32'(exp_lat));
    chk("ready_done", 32'(in_ready20 | in_ready16), 0);
    chk("acc20", 32'(acc20), 32'(sum % (64'd1 << 20)));
    chk("ovf20", 32'(ovf20), 32'(sum >= (64'd1 << 20)));
    chk("acc16", 32'(acc16), 32'(sum % (64'd1 << 16)));
    chk("ovf16", 32'(ovf16), 32'(sum >= (64'd1 << 16)));

    if (start_in_done) begin
      start = 1'b1;
      len   = 4'd1;
    end
    tick();
    chk("done_pulse", 32'(done20 | done16), 0);
    chk("idle_busy", 32'(busy20 | busy16), 0);
    chk("acc_hold", 32'(acc20), 32'(sum % (64'd1 << 20)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk_reset_vals("rst_held");
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("rst_rel");

    // Directed: no stalls, then a 2-cycle stall between pairs 1 and 2.
    pa[0] = 255; pb[0] = 255; st[0] = 0;
    pa[1] = 2;   pb[1] = 3;   st[1] = 0;
    pa[2] = 0;   pb[2] = 7;   st[2] = 0;
    run_burst(3, 1'b0, 1'b0);
    st[1] = 2;
    run_burst(3, 1'b0, 1'b0);
    run_burst(0, 1'b0, 1'b0);

    // 16-bit instance wraps here; the next start must clear its ovf.
    pa[0] = 255; pb[0] = 255; st[0] = 0;
    pa[1] = 255; pb[1] = 255; st[1] = 0;
    run_burst(2, 1'b0, 1'b0);

    // Asynchronous reset after the 2nd of 4 pairs.
    start = 1'b1;
    len   = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(100 + i);
      in_b     = 8'(50 + i);
      chk("mid_ready", 32'(in_ready20), 1);
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("post_rst");
    pa[0] = 10; pb[0] = 20; st[0] = 0;
    run_burst(1, 1'b0, 1'b0);

    // start held through RUN and raised in DONE, then taken in IDLE.
    pa[0] = 5; pb[0] = 7; st[0] = 1;
    pa[1] = 6; pb[1] = 8; st[1] = 0;
    run_burst(2, 1'b1, 1'b1);
    pa[0] = 3; pb[0] = 4; st[0] = 0;
    run_burst(1, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin
        pa[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        pb[i] = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        st[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      run_burst(n, 1'($urandom_range(0, 1)), (r == 24) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the shared 8x8 Wallace multiplier in the MAC datapath. It accepts a burst request of `len` operand pairs and streams them through a valid/ready handshake into registered multiplier inputs. It accumulates the products into a wide accumulator and pulses `done` when the burst is complete. The multiplier stays a separate combinational block: this controller drives its inputs and reads its 16-bit product.

## Interface
- `ACC_W`, default 20: accumulator width. 20 bits covers 15 × 65025 with no overflow.
- `CNT_W`, default 4: width of the burst-length field. Maximum burst is 2^CNT_W − 1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  burst request. Sampled only in IDLE.
- `len`  in  CNT_W  number of operand pairs. Sampled with `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept a pair.
- `in_a`  in  8  multiplicand.
- `in_b`  in  8  multiplier.
- `mul_a`  out  8  registered operand to the multiplier's `a` input.
- `mul_b`  out  8  registered operand to the multiplier's `b` input.
- `mul_p`  in  16  product from the multiplier's `asn` output. Combinational from `mul_a`/`mul_b`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the burst completes.
- `acc`  out  ACC_W  accumulated sum. Held until the next accepted `start`.
- `ovf`  out  1  sticky carry-out of the accumulator. Cleared on `start`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**, when `start` = 1:
  - Clear `acc`, `ovf` and `op_v`.
  - Load `remaining` ← `len`.
  - If `len` ≠ 0, go to RUN. If `len` = 0, go to DONE.
- **RUN**:
  - `in_ready` = (`remaining` ≠ 0).
  - On a handshake (`in_valid` & `in_ready`): `mul_a` ← `in_a`, `mul_b` ← `in_b`, `op_v` ← 1, `remaining` ← `remaining` − 1.
  - With no handshake: `op_v` ← 0, and `mul_a`/`mul_b` hold.
  - Whenever `op_v` = 1: `{carry, acc}` ← `acc` + zero-extended `mul_p`, and `ovf` ← `ovf` | carry. The accumulator wraps modulo 2^ACC_W.
  - The handshake that takes `remaining` to 0 moves the FSM to DRAIN.
- **DRAIN**:
  - `in_ready` = 0.
  - Add the final product (`op_v` = 1), clear `op_v`, go to DONE.
- **DONE**:
  - `done` = 1 for exactly one cycle.
  - Go to IDLE. `start` is ignored in this state.
- `start` is ignored in RUN, DRAIN and DONE; no queuing.
- `in_valid` is ignored whenever `in_ready` = 0. The source must hold the pair until the handshake.
- `in_ready` is a function of state and `remaining` only. It does not depend combinationally on `in_valid`.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mul_a` 0, `mul_b` 0, `acc` 0, `ovf` 0, `done` 0, `busy` 0, `remaining` 0, `op_v` 0.
- Reset asserted mid-burst returns to IDLE immediately. No `done` pulse; the partial `acc` is discarded.
- Handshake at edge E:
  - The operands appear on `mul_a`/`mul_b` after E.
  - The product is added into `acc` at edge E+1.
- Throughput is one pair per cycle with `in_valid` held high.
- Burst latency with no stalls, for N ≥ 1 pairs and `start` at edge S:
  - `in_ready` is high in cycles S+1 … S+N.
  - DRAIN occupies the cycle after S+N.
  - `done` is high in cycle S+N+2.
  - The FSM is back in IDLE at S+N+3.
- `len` = 0: `done` is high in the cycle after `start`; `acc` = 0.
- `acc` and `ovf` are final and stable in the `done` cycle. They hold through IDLE.
- Source stalls (`in_valid` low) stretch RUN. The accumulator skips those cycles because `op_v` = 0.

## Test plan
- Default parameters, `len`=3, pairs (255,255), (2,3), (0,7) with `in_valid` held → `done` high 5 cycles after `start`; `acc`=65031; `ovf`=0.
- Same burst with `in_valid` low for 2 cycles between the 1st and 2nd pair → `in_ready` stays high; `acc`=65031; `done` is delayed exactly 2 cycles.
- `len`=0 → `done` pulses one cycle after `start`; `acc`=0; `in_ready` never asserts.
- `ACC_W`=16, `len`=2, pairs (255,255) twice → `acc`=64514 (130050 mod 65536); `ovf`=1. The next `start` clears `ovf` to 0.
- `rst` pulsed after the 2nd of 4 pairs → all outputs return to reset values asynchronously; no `done`. A new `len`=1 burst with (10,20) then gives `acc`=200.
- `start` asserted in RUN and again in the DONE cycle → both ignored. `start` in the following IDLE cycle is accepted and `busy` rises.
